// File: rtl/ram_arbiter.sv
// Round-robin arbiter that shares one RAM port among NREQ cache requesters.
// Holds each grant until RAM reports ACCESS or ERROR, or until the requester withdraws.
module ram_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [NREQ-1:0]    req_ren,
    input  logic [NREQ-1:0]    req_wen,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_store,
    output logic [NREQ-1:0]    req_wait,
    output logic [DW-1:0]      req_load,
    input  logic [1:0]         ramstate,
    input  logic [DW-1:0]      ramload,
    output logic               ramREN,
    output logic               ramWEN,
    output logic [AW-1:0]      ramaddr,
    output logic [DW-1:0]      ramstore,
    output logic               gnt_valid,
    output logic [IW-1:0]      gnt_id,
    output logic               err
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            found;
    logic            err_n;
    logic [NREQ-1:0] pending;
    logic            gnt_pend;
    logic [AW-1:0]   addr_a  [NREQ];
    logic [DW-1:0]   store_a [NREQ];

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        return (v == IW'(NREQ - 1)) ? '0 : v + 1'b1;
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*AW +: AW];
        assign store_a[i] = req_store[i*DW +: DW];
    end

    assign pending   = req_ren | req_wen;
    assign gnt_pend  = pending[gnt_id];
    assign gnt_valid = (state == GRANT);
    assign req_load  = ramload;

    // First pending requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && pending[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        state_n  = state;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        req_wait = '1;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) state_n = GRANT;
            end
            GRANT: begin
                ramaddr  = addr_a[gnt_id];
                ramstore = store_a[gnt_id];
                if (!gnt_pend) begin
                    // Withdrawn requester: abort without touching the RAM.
                    state_n = IDLE;
                end else begin
                    ramWEN = req_wen[gnt_id];
                    ramREN = req_ren[gnt_id] & ~req_wen[gnt_id];
                    if (ramstate == RAM_ACCESS || ramstate == RAM_ERROR) begin
                        req_wait[gnt_id] = 1'b0;
                        state_n          = IDLE;
                        err_n            = (ramstate == RAM_ERROR);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            gnt_id <= '0;
            rr_ptr <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            err   <= err_n;
            if (state == IDLE && found) gnt_id <= pick;
            if (state == GRANT && state_n == IDLE) rr_ptr <= wrap_inc(gnt_id);
        end
    end

endmodule
